// File: rtl/cim_pkg.sv
// Shared CIM constants and the readout-accumulator state encoding.
package cim_pkg;

  localparam int unsigned CIM_ROWS   = 144;
  localparam int unsigned CIM_NBIT   = 4;
  localparam int unsigned CIM_PSUM_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } rdacc_state_t;

endpackage

// File: rtl/cim_rdacc_lane.sv
// Single-column shift-add accumulator: MSB plane first, each later plane
// doubles the running sum before adding. acc_c exposes the value the
// register will take on an enabled edge so the top can capture the final sum.
module cim_rdacc_lane #(
  parameter int unsigned PSUM_W = 8,
  parameter int unsigned ACC_W  = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              en,
  input  logic [PSUM_W-1:0] psum,
  output logic [ACC_W-1:0]  acc_c
);

  logic [ACC_W-1:0] acc_q;

  // Next accumulator value; clr restarts the sum at the first plane.
  always_comb begin
    acc_c = ACC_W'(psum);
    if (!clr) acc_c = (acc_q << 1) + ACC_W'(psum);
  end

  // Accumulator register, advances only when a plane is consumed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   acc_q <= '0;
    else if (en) acc_q <= acc_c;
  end

endmodule

// File: rtl/cim_rdacc.sv
// Bit-serial readout accumulator: steps the driver plane select MSB->LSB,
// shift-accumulates one partial sum per plane per column and presents the
// per-column MAC result over a valid/ready handshake.
module cim_rdacc
  import cim_pkg::*;
#(
  parameter  int unsigned NCOL   = 4,
  parameter  int unsigned PSUM_W = CIM_PSUM_W,
  parameter  int unsigned NBIT   = CIM_NBIT,
  localparam int unsigned ACC_W  = PSUM_W + NBIT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start_i,
  input  logic                   cima_i,
  output logic                   busy_o,
  output logic [3:0]             sel_o,
  output logic                   cima_o,
  input  logic                   psum_valid_i,
  input  logic [NCOL*PSUM_W-1:0] psum_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [NCOL*ACC_W-1:0]  out_data_o,
  output logic                   out_cima_o
);

  rdacc_state_t            state_q, state_d;
  logic [1:0]              plane_q, plane_d;
  logic                    cima_q, cima_d;
  logic                    valid_q, valid_d;
  logic                    busy_q;
  logic                    out_cima_q;
  logic [NCOL*ACC_W-1:0]   data_q;
  logic [NCOL*ACC_W-1:0]   acc_c;
  logic                    lane_en, lane_clr, cap;

  // Next-state, plane sequencing and lane control.
  always_comb begin
    state_d  = state_q;
    plane_d  = plane_q;
    cima_d   = cima_q;
    valid_d  = valid_q;
    lane_en  = 1'b0;
    lane_clr = 1'b0;
    cap      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cima_d  = cima_i;
          plane_d = 2'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (psum_valid_i) begin
          lane_en  = 1'b1;
          lane_clr = (plane_q == 2'd0);
          if (plane_q == 2'(NBIT - 1)) begin
            plane_d = 2'd0;
            cap     = 1'b1;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            plane_d = plane_q + 2'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          valid_d = 1'b0;
          if (start_i) begin
            cima_d  = cima_i;
            plane_d = 2'd0;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      plane_q    <= 2'd0;
      cima_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      out_cima_q <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      cima_q  <= cima_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != IDLE);
      if (cap) begin
        data_q     <= acc_c;
        out_cima_q <= cima_q;
      end
    end
  end

  // One accumulator lane per column.
  for (genvar c = 0; c < NCOL; c++) begin : g_lane
    cim_rdacc_lane #(
      .PSUM_W (PSUM_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (lane_clr),
      .en    (lane_en),
      .psum  (psum_i[c*PSUM_W +: PSUM_W]),
      .acc_c (acc_c[c*ACC_W +: ACC_W])
    );
  end

  assign busy_o      = busy_q;
  assign sel_o       = {2'b00, plane_q};
  assign cima_o      = cima_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_cima_o  = out_cima_q;

endmodule

// File: tb/tb_cim_rdacc.sv
// Directed bench for cim_rdacc with a queue-based scoreboard.
module tb_cim_rdacc;

  localparam int unsigned NCOL   = 4;
  localparam int unsigned PSUM_W = 8;
  localparam int unsigned ACC_W  = 12;
  localparam int unsigned DW     = NCOL * PSUM_W;
  localparam int unsigned AW     = NCOL * ACC_W;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start_i = 1'b0;
  logic          cima_i = 1'b0;
  logic          busy_o;
  logic [3:0]    sel_o;
  logic          cima_o;
  logic          psum_valid_i = 1'b0;
  logic [DW-1:0] psum_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [AW-1:0] out_data_o;
  logic          out_cima_o;

  typedef struct packed {
    logic [AW-1:0] d;
    logic          c;
  } exp_t;

  exp_t          sbq[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  logic [DW-1:0] pl [4];
  int            gp [4];

  cim_rdacc u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (start_i),
    .cima_i       (cima_i),
    .busy_o       (busy_o),
    .sel_o        (sel_o),
    .cima_o       (cima_o),
    .psum_valid_i (psum_valid_i),
    .psum_i       (psum_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_cima_o   (out_cima_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pk(input int unsigned a0, a1, a2, a3);
    logic [DW-1:0] v;
    v = {PSUM_W'(a3), PSUM_W'(a2), PSUM_W'(a1), PSUM_W'(a0)};
    return v;
  endfunction

  function automatic logic [AW-1:0] pa(input int unsigned a0, a1, a2, a3);
    logic [AW-1:0] v;
    v = {ACC_W'(a3), ACC_W'(a2), ACC_W'(a1), ACC_W'(a0)};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every valid cycle checks against the queue head, pops on handshake.
  always @(negedge clk) begin
    if (rstn && out_valid_o) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid: got data %0h with empty scoreboard", out_data_o);
      end else if (out_data_o !== sbq[0].d || out_cima_o !== sbq[0].c) begin
        n_bad++;
        $display("FAIL result: got data %0h cima %0b expected data %0h cima %0b",
                 out_data_o, out_cima_o, sbq[0].d, sbq[0].c);
        if (out_ready_i) void'(sbq.pop_front());
      end else if (out_ready_i) begin
        void'(sbq.pop_front());
      end
    end
  end

  task automatic start_op(input logic c);
    start_i = 1'b1;
    cima_i  = c;
    tick();
    start_i = 1'b0;
    cima_i  = ~c;
    check("start_busy", 64'(busy_o), 64'd1);
    check("start_sel", 64'(sel_o), 64'd0);
    check("start_cima", 64'(cima_o), 64'(c));
  endtask

  // Feeds planes lo..hi from pl[] with gp[] idle cycles before each.
  task automatic feed(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) begin
      for (int g = 0; g < gp[p]; g++) begin
        psum_valid_i = 1'b0;
        psum_i = DW'($urandom);
        tick();
        check("sel_gap", 64'(sel_o), 64'(p));
      end
      check("sel_plane", 64'(sel_o), 64'(p));
      psum_valid_i = 1'b1;
      psum_i = pl[p];
      tick();
      psum_valid_i = 1'b0;
      psum_i = DW'($urandom);
      check(p == 3 ? "valid_rise" : "valid_early", 64'(out_valid_o), (p == 3) ? 64'd1 : 64'd0);
    end
  endtask

  // Holds ready low for dly cycles, optionally poking start meanwhile, then hands off.
  task automatic drain(input int dly, input bit poke_start);
    for (int i = 0; i < dly; i++) begin
      start_i = poke_start && (i == 1);
      tick();
    end
    start_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("post_valid", 64'(out_valid_o), 64'd0);
    check("post_busy", 64'(busy_o), 64'd0);
  endtask

  task automatic load_a();
    pl[0] = pk(144, 1, 0, 3);
    pl[1] = pk(144, 0, 0, 2);
    pl[2] = pk(144, 0, 0, 1);
    pl[3] = pk(144, 0, 1, 0);
  endtask

  task automatic load_b();
    pl[0] = pk(255, 10, 0, 7);
    pl[1] = pk(255, 20, 0, 0);
    pl[2] = pk(255, 30, 0, 7);
    pl[3] = pk(255, 40, 0, 0);
  endtask

  task automatic no_gaps();
    for (int i = 0; i < 4; i++) gp[i] = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_sel"}, 64'(sel_o), 64'd0);
    check({tag, "_cima"}, 64'(cima_o), 64'd0);
    check({tag, "_valid"}, 64'(out_valid_o), 64'd0);
    check({tag, "_data"}, 64'(out_data_o), 64'd0);
    check({tag, "_ocima"}, 64'(out_cima_o), 64'd0);
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] exp_a, exp_b;
    int t_a, t_b, w;
    exp_a = pa(2160, 8, 1, 34);
    exp_b = pa(3825, 260, 0, 70);
    no_gaps();

    // Reset values.
    #12;
    check_reset_outputs("rst");
    rstn = 1'b1;
    tick();

    // psum_valid in IDLE is ignored.
    psum_valid_i = 1'b1;
    psum_i = pk(9, 9, 9, 9);
    tick();
    tick();
    psum_valid_i = 1'b0;
    check("idle_psum_busy", 64'(busy_o), 64'd0);
    check("idle_psum_sel", 64'(sel_o), 64'd0);
    check("idle_psum_valid", 64'(out_valid_o), 64'd0);

    // Max value and plane weighting, no stalls.
    load_a();
    sbq.push_back('{d: exp_a, c: 1'b1});
    start_op(1'b1);
    feed(0, 3);
    drain(0, 1'b0);

    // Second pattern; start ignored in ISSUE and in HOLD without ready.
    load_b();
    sbq.push_back('{d: exp_b, c: 1'b0});
    start_op(1'b0);
    feed(0, 1);
    start_i = 1'b1;
    cima_i  = 1'b1;
    tick();
    start_i = 1'b0;
    check("issue_start_cima", 64'(cima_o), 64'd0);
    check("issue_start_sel", 64'(sel_o), 64'd2);
    feed(2, 3);
    drain(3, 1'b1);

    // psum_valid in IDLE leaves the held result untouched.
    psum_valid_i = 1'b1;
    psum_i = pk(1, 2, 3, 4);
    tick();
    psum_valid_i = 1'b0;
    check("idle_psum_data", 64'(out_data_o), 64'(exp_b));
    check("idle_psum_sel2", 64'(sel_o), 64'd0);

    // Stalls between planes and a 5-cycle ready stall.
    load_a();
    for (int i = 0; i < 4; i++) gp[i] = i;
    sbq.push_back('{d: exp_a, c: 1'b1});
    start_op(1'b1);
    feed(0, 3);
    drain(5, 1'b0);
    no_gaps();

    // Reset mid-ISSUE after two planes.
    load_b();
    start_op(1'b1);
    feed(0, 1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick();
    tick();
    check_reset_outputs("abort_hold");
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_valid", 64'(out_valid_o), 64'd0);
    end
    load_a();
    sbq.push_back('{d: exp_a, c: 1'b1});
    start_op(1'b1);
    feed(0, 3);
    drain(0, 1'b0);

    // Back-to-back: second start rides the handshake cycle.
    load_a();
    sbq.push_back('{d: exp_a, c: 1'b1});
    start_op(1'b1);
    feed(0, 3);
    t_a = cyc;
    sbq.push_back('{d: exp_b, c: 1'b0});
    out_ready_i = 1'b1;
    start_i = 1'b1;
    cima_i = 1'b0;
    tick();
    out_ready_i = 1'b0;
    start_i = 1'b0;
    check("b2b_busy", 64'(busy_o), 64'd1);
    check("b2b_valid_drop", 64'(out_valid_o), 64'd0);
    check("b2b_cima", 64'(cima_o), 64'd0);
    check("b2b_held_ocima", 64'(out_cima_o), 64'd1);
    load_b();
    feed(0, 3);
    t_b = cyc;
    check("b2b_period", 64'(t_b - t_a), 64'd5);
    drain(0, 1'b0);

    // Scoreboard must be empty within a bounded wait.
    w = 0;
    while (sbq.size() != 0 && w < 20) begin
      tick();
      w++;
    end
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cim_rdacc.md
# cim_rdacc

Bit-serial readout accumulator and plane sequencer on the receive side of the read-wordline driver. It steps the driver's 2-bit plane select from MSB to LSB and captures one per-column partial sum per plane from the column adder tree. It then shift-accumulates the four planes into a full 4-bit-input MAC result per column and hands that result downstream over a valid/ready handshake. It sits between the CIM macro column outputs and the output buffer, and it owns `sel`/`cima` sequencing for one operation.

## Interface
- `NCOL`, default 4: columns accumulated in parallel.
- `PSUM_W`, default 8: per-column partial-sum width; unsigned, max 144.
- `NBIT`, default 4: input bit planes per operation.
- `ACC_W`, default `PSUM_W+NBIT`: per-column result width; derived, not overridden.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start_i` in 1: request one MAC operation.
- `cima_i` in 1: row select for the operation; sampled on accepted start.
- `busy_o` out 1: high outside IDLE.
- `sel_o` out 4: plane select to the driver. `[1:0]` = plane index, `00` = MSB. `[3:2]` are always 0.
- `cima_o` out 1: latched `cima_i`, driven to the driver.
- `psum_valid_i` in 1: `psum_i` holds the sums for the plane currently on `sel_o`.
- `psum_i` in `NCOL*PSUM_W`: column c at `[c*PSUM_W +: PSUM_W]`.
- `out_valid_o` out 1: result available.
- `out_ready_i` in 1: downstream accepts.
- `out_data_o` out `NCOL*ACC_W`: column c at `[c*ACC_W +: ACC_W]`.
- `out_cima_o` out 1: cima tag of the result.

## Operation
States:
- **IDLE**
  - Accepted `start_i` latches `cima_i` into `cima_o`.
  - Clears plane count and `sel_o`.
  - Next state: ISSUE.
- **ISSUE**
  - `sel_o[1:0]` = plane count.
  - On `psum_valid_i`, per column: `acc = (plane==0) ? psum : (acc<<1) + psum`.
  - Plane count and `sel_o` then increment.
  - On plane `NBIT-1` the accumulators load `out_data_o`, raise `out_valid_o` and go to HOLD.
  - With no `psum_valid_i` the block waits indefinitely; `sel_o` holds.
- **HOLD**
  - `out_valid_o`=1; `out_data_o` and `out_cima_o` stay stable until `out_ready_i`.
  - `out_valid_o & out_ready_i` completes the transfer.
  - With `start_i` also high in that cycle, the start is accepted and the next state is ISSUE (back-to-back); otherwise the next state is IDLE.

Rules:
- `start_i` in ISSUE, or in HOLD without `out_ready_i`, is ignored; it is not queued.
- `psum_valid_i` outside ISSUE is ignored.
- Arithmetic is unsigned, no saturation. Max 144·15 = 2160 fits `ACC_W`=12.
- `psum_i` values above 2^PSUM_W−1 cannot occur by width.

## Timing
- Reset values:
  - State IDLE.
  - `busy_o`=0, `sel_o`=0, `cima_o`=0.
  - `out_valid_o`=0, `out_data_o`=0, `out_cima_o`=0.
  - Accumulators and plane count 0.
- Reset mid-operation aborts immediately; partial results are discarded and no `out_valid_o` pulse follows.
- All outputs are registered.
- `sel_o` changes only on the edge that consumes a `psum_valid_i`, or on an accepted start.
- Latency:
  - `start_i` at edge 0 gives `busy_o`=1 and `sel_o`=0 after edge 0.
  - With `psum_valid_i` high every cycle, the four planes are consumed at edges 1–4.
  - `out_valid_o`=1 after edge 4.
  - Minimum start-to-valid is 4 cycles; minimum operation period back-to-back is 5 cycles.
- `out_data_o` only updates on the plane-`NBIT-1` capture edge.

## Structure
- Shared package `cim_pkg`:
  - `CIM_ROWS`=144, `CIM_NBIT`=4, `CIM_PSUM_W`=8.
  - State enum `rdacc_state_t` {IDLE, ISSUE, HOLD}.
- Top-level contents: FSM, plane counter, `cima`/`sel` registers, output register.
- One sub-module, `cim_rdacc_lane`: a single-column shift-add accumulator with `clr`, `en` and `psum` inputs. It is instantiated `NCOL` times in a generate loop.

## Test plan
- **Reset:**
  - Stimulus: assert `rstn`=0 mid-ISSUE after 2 planes, release, then run one full operation.
  - Required: all outputs 0 during reset, no stale `out_valid_o`, and the next result is unaffected by the aborted partials.
- **Max value:**
  - Stimulus: `cima_i`=1, col0 psums 144,144,144,144.
  - Required: `out_data_o` col0 = 2160, `out_cima_o`=1, `sel_o` sequence 0,1,2,3.
- **Plane weighting:**
  - Stimulus: col1 psums 1,0,0,0 and col2 psums 0,0,0,1.
  - Required: col1 = 8, col2 = 1.
- **Stalls:**
  - Stimulus: `psum_valid_i` gaps of 0–3 cycles between planes, and `out_ready_i` low for 5 cycles in HOLD.
  - Required: `sel_o` holds during gaps, `out_data_o` stable throughout HOLD, result identical to the no-stall run.
- **Back-to-back:**
  - Stimulus: `start_i` asserted in the same cycle as the HOLD `out_ready_i` handshake.
  - Required: the second operation starts without an IDLE cycle, with period 5 cycles.
- **Ignored inputs:**
  - Stimulus: `start_i` during ISSUE and `psum_valid_i` in IDLE.
  - Required: no state change and no accumulator change.
